bram_pingpong_ctrl: RTL and testbench

- Controller and arbiter for the shared single-port median-buffer BRAM.
- BRAM holds 2 banks of BANK_DEPTH words.
- Write requester (median writer) fills one bank while the read requester drains the other.
- Sequences bank ownership, arbitrates the single BRAM port per cycle and signals bank-ready to the reader.

---
 rtl/bram_pp_pkg.sv | 33 +++
 rtl/bram_pingpong_ctrl_if.sv | 42 ++++
 rtl/bram_rr_arb.sv | 38 +++
 rtl/bram_pingpong_ctrl.sv | 128 ++++++++++++
 tb/tb_bram_pingpong_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bram_pp_pkg.sv
// rtl/bram_pp_pkg.sv - shared types and defaults for the ping-pong BRAM controller
//
// Purpose : bank state / grant encodings, default sizing constants and
//           small helpers that classify a bank state.
// Ports   : none (package)
package bram_pp_pkg;

   typedef enum logic [1:0] {
      EMPTY    = 2'd0,
      FILLING  = 2'd1,
      FULL     = 2'd2,
      DRAINING = 2'd3
   } bank_state_t;

   typedef enum logic {
      GNT_WRITE = 1'b0,
      GNT_READ  = 1'b1
   } grant_t;

   localparam int DEF_DATA_W     = 16;
   localparam int DEF_BANK_DEPTH = 8;

   // A bank accepts writer traffic until it has been completely filled.
   function automatic logic bank_writable(input bank_state_t s);
      return (s == EMPTY) || (s == FILLING);
   endfunction

   // A bank is offered to the reader only once it is complete.
   function automatic logic bank_readable(input bank_state_t s);
      return (s == FULL) || (s == DRAINING);
   endfunction

endpackage

// File: rtl/bram_pingpong_ctrl_if.sv
// rtl/bram_pingpong_ctrl_if.sv - writer, reader and BRAM-port bundle
//
// Purpose : groups the writer handshake, reader handshake and BRAM port.
// Ports   : slave  - controller view (requests/bram_dout in, the rest out)
//           master - environment view (requests/bram_dout out, the rest in)
interface bram_pingpong_ctrl_if
   import bram_pp_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int BANK_DEPTH = DEF_BANK_DEPTH
);
   localparam int ADDR_W = $clog2(2 * BANK_DEPTH);

   logic              wr_req;
   logic [DATA_W-1:0] wr_data;
   logic              wr_ack;
   logic              wr_stall;

   logic              rd_req;
   logic              rd_avail;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              rd_last;

   logic              bram_we;
   logic [ADDR_W-1:0] bram_addr;
   logic [DATA_W-1:0] bram_din;
   logic [DATA_W-1:0] bram_dout;

   modport slave (
      input  wr_req, wr_data, rd_req, bram_dout,
      output wr_ack, wr_stall, rd_avail, rd_data, rd_valid, rd_last,
             bram_we, bram_addr, bram_din
   );

   modport master (
      output wr_req, wr_data, rd_req, bram_dout,
      input  wr_ack, wr_stall, rd_avail, rd_data, rd_valid, rd_last,
             bram_we, bram_addr, bram_din
   );

endinterface

// File: rtl/bram_rr_arb.sv
// rtl/bram_rr_arb.sv - two-way round-robin arbiter for the single BRAM port
//
// Purpose : grants at most one of write/read per cycle; on contention the
//           side that did not win last time is granted.
// Ports   : clk, rst          - clock, synchronous active-high reset
//           i_req_wr/i_req_rd - eligible requests (already qualified)
//           o_gnt_wr/o_gnt_rd - same-cycle grants, mutually exclusive
module bram_rr_arb
   import bram_pp_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic i_req_wr,
   input  logic i_req_rd,
   output logic o_gnt_wr,
   output logic o_gnt_rd
);

   grant_t r_last_grant;

   always_comb begin
      o_gnt_wr = i_req_wr && (!i_req_rd || (r_last_grant == GNT_READ));
      o_gnt_rd = i_req_rd && (!i_req_wr || (r_last_grant == GNT_WRITE));
   end

   // Only an actual grant moves the pointer, so an idle cycle does not
   // change who wins the next contention.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_last_grant <= GNT_READ;
      end else if (o_gnt_wr) begin
         r_last_grant <= GNT_WRITE;
      end else if (o_gnt_rd) begin
         r_last_grant <= GNT_READ;
      end
   end

endmodule

// File: rtl/bram_pingpong_ctrl.sv
// rtl/bram_pingpong_ctrl.sv - ping-pong bank sequencer and port arbiter for the median-buffer BRAM
//
// Purpose : the writer fills one bank while the reader drains the other;
//           bank states and pointers live here, port arbitration is
//           delegated to bram_rr_arb.
// Ports   : clk, rst - clock, synchronous active-high reset
//           bus      - writer (wr_req/wr_data/wr_ack/wr_stall),
//                      reader (rd_req/rd_avail/rd_data/rd_valid/rd_last),
//                      BRAM port (bram_we/bram_addr/bram_din/bram_dout)
module bram_pingpong_ctrl
   import bram_pp_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int BANK_DEPTH = DEF_BANK_DEPTH
)(
   input  logic                 clk,
   input  logic                 rst,
   bram_pingpong_ctrl_if.slave  bus
);

   localparam int ADDR_W = $clog2(2 * BANK_DEPTH);
   localparam int IDX_W  = ADDR_W - 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BANK_DEPTH - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

   bank_state_t       r_bank_st [2];
   logic              r_wr_bank;
   logic              r_rd_bank;
   logic [IDX_W-1:0]  r_wr_idx;
   logic [IDX_W-1:0]  r_rd_idx;
   logic [ADDR_W-1:0] r_addr;
   logic              r_rd_valid;
   logic              r_rd_last;

   logic              w_wr_open;
   logic              w_rd_open;
   logic              w_wr_elig;
   logic              w_rd_elig;
   logic              w_gnt_wr;
   logic              w_gnt_rd;
   logic [ADDR_W-1:0] w_wr_addr;
   logic [ADDR_W-1:0] w_rd_addr;
   logic [ADDR_W-1:0] w_addr;

   assign w_wr_open = bank_writable(r_bank_st[r_wr_bank]);
   assign w_rd_open = bank_readable(r_bank_st[r_rd_bank]);

   // Requests are masked during reset so no access leaks out in that cycle.
   assign w_wr_elig = !rst && bus.wr_req && w_wr_open;
   assign w_rd_elig = !rst && bus.rd_req && w_rd_open;

   assign w_wr_addr = {r_wr_bank, r_wr_idx};
   assign w_rd_addr = {r_rd_bank, r_rd_idx};

   bram_rr_arb u_arb (
      .clk      (clk),
      .rst      (rst),
      .i_req_wr (w_wr_elig),
      .i_req_rd (w_rd_elig),
      .o_gnt_wr (w_gnt_wr),
      .o_gnt_rd (w_gnt_rd)
   );

   // The address follows the granted side; an idle cycle keeps the last
   // address on the port to avoid needless toggling.
   always_comb begin
      w_addr = r_addr;
      if (w_gnt_wr) begin
         w_addr = w_wr_addr;
      end else if (w_gnt_rd) begin
         w_addr = w_rd_addr;
      end
   end

   assign bus.bram_we   = w_gnt_wr;
   assign bus.wr_ack    = w_gnt_wr;
   assign bus.bram_addr = rst ? '0 : w_addr;
   assign bus.bram_din  = w_gnt_wr ? bus.wr_data : '0;
   assign bus.wr_stall  = !rst && !w_wr_open;
   assign bus.rd_avail  = !rst && w_rd_open;

   // bram_dout already carries the word addressed last cycle, so it is
   // passed straight through while the registered valid is high.
   assign bus.rd_valid  = !rst && r_rd_valid;
   assign bus.rd_last   = !rst && r_rd_last;
   assign bus.rd_data   = (!rst && r_rd_valid) ? bus.bram_dout : '0;

   // Grants are exclusive, so at most one bank changes state per cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_bank_st[0] <= EMPTY;
         r_bank_st[1] <= EMPTY;
         r_wr_bank    <= 1'b0;
         r_rd_bank    <= 1'b0;
         r_wr_idx     <= '0;
         r_rd_idx     <= '0;
         r_addr       <= '0;
         r_rd_valid   <= 1'b0;
         r_rd_last    <= 1'b0;
      end else begin
         r_rd_valid <= w_gnt_rd;
         r_rd_last  <= w_gnt_rd && (r_rd_idx == IDX_LAST);

         if (w_gnt_wr) begin
            r_addr <= w_wr_addr;
            if (r_wr_idx == IDX_LAST) begin
               r_bank_st[r_wr_bank] <= FULL;
               r_wr_idx             <= '0;
               r_wr_bank            <= ~r_wr_bank;
            end else begin
               r_bank_st[r_wr_bank] <= FILLING;
               r_wr_idx             <= r_wr_idx + IDX_ONE;
            end
         end else if (w_gnt_rd) begin
            r_addr <= w_rd_addr;
            if (r_rd_idx == IDX_LAST) begin
               r_bank_st[r_rd_bank] <= EMPTY;
               r_rd_idx             <= '0;
               r_rd_bank            <= ~r_rd_bank;
            end else begin
               r_bank_st[r_rd_bank] <= DRAINING;
               r_rd_idx             <= r_rd_idx + IDX_ONE;
            end
         end
      end
   end

endmodule

// File: tb/tb_bram_pingpong_ctrl.sv
// tb/tb_bram_pingpong_ctrl.sv - self-checking bench for bram_pingpong_ctrl
module tb_bram_pingpong_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int n_tests = 0;
   int n_fail  = 0;

   logic [16:0] sb_q [$];
   logic [16:0] sb_exp;
   logic [3:0]  exp_wa = '0;
   logic [3:0]  exp_ra = '0;
   logic [2:0]  wcnt   = '0;

   logic [15:0] mem [16];

   bram_pingpong_ctrl_if #(.DATA_W(16), .BANK_DEPTH(8)) bus ();

   bram_pingpong_ctrl #(.DATA_W(16), .BANK_DEPTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.bram_we === 1'b1) mem[bus.bram_addr] <= bus.bram_din;
      bus.bram_dout <= mem[bus.bram_addr];
   end

   always @(negedge clk) begin
      if (bus.rd_valid === 1'b1) begin
         n_tests++;
         if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL rd_unexpected: rd_valid=1 data=%h, no word expected", bus.rd_data);
         end else begin
            sb_exp = sb_q.pop_front();
            if ({bus.rd_last, bus.rd_data} !== sb_exp) begin
               n_fail++;
               $display("FAIL rd_word: got last=%b data=%h, want last=%b data=%h",
                        bus.rd_last, bus.rd_data, sb_exp[16], sb_exp[15:0]);
            end
         end
      end
      if (bus.bram_we === 1'b1) begin
         n_tests++;
         if (bus.wr_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL we_implies_ack: bram_we=1 wr_ack=%b", bus.wr_ack);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic model_push(input logic [15:0] d);
      sb_q.push_back({(wcnt == 3'd7), d});
      exp_wa = exp_wa + 4'd1;
      wcnt   = wcnt + 3'd1;
   endtask

   task automatic model_flush();
      sb_q.delete();
      exp_wa = '0;
      exp_ra = '0;
      wcnt   = '0;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      bus.wr_req = 1'b0;
      bus.rd_req = 1'b0;
      model_flush();
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic write_word(input logic [15:0] d);
      bit got = 0;
      bus.wr_req  = 1'b1;
      bus.wr_data = d;
      for (int n = 0; n < 8 && !got; n++) begin
         @(negedge clk);
         if (bus.wr_ack === 1'b1) begin
            got = 1;
            n_tests++;
            if (bus.bram_addr !== exp_wa || bus.bram_din !== d || bus.bram_we !== 1'b1) begin
               n_fail++;
               $display("FAIL wr_access: addr=%0d din=%h we=%b, want addr=%0d din=%h we=1",
                        bus.bram_addr, bus.bram_din, bus.bram_we, exp_wa, d);
            end
            model_push(d);
         end
         @(posedge clk); #1;
      end
      bus.wr_req = 1'b0;
      n_tests++;
      if (!got) begin
         n_fail++;
         $display("FAIL wr_ack_timeout: no wr_ack for data %h within 8 cycles", d);
      end
   endtask

   task automatic read_word();
      bus.rd_req = 1'b1;
      @(negedge clk);
      n_tests++;
      if (bus.bram_we !== 1'b0 || bus.wr_ack !== 1'b0 || bus.bram_addr !== exp_ra) begin
         n_fail++;
         $display("FAIL rd_issue: addr=%0d we=%b ack=%b, want addr=%0d we=0 ack=0",
                  bus.bram_addr, bus.bram_we, bus.wr_ack, exp_ra);
      end
      @(posedge clk); #1;
      bus.rd_req = 1'b0;
      exp_ra = exp_ra + 4'd1;
      @(negedge clk);
      n_tests++;
      if (bus.rd_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL rd_valid_latency: rd_valid=%b one cycle after issue, want 1", bus.rd_valid);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.wr_req  = 1'b0;
      bus.rd_req  = 1'b0;
      bus.wr_data = 16'hFFFF;
      @(posedge clk); #1;
      @(negedge clk);
      n_tests++;
      if ({bus.wr_ack, bus.bram_we, bus.rd_valid, bus.rd_last, bus.rd_avail, bus.wr_stall} !== 6'b0 ||
          bus.bram_addr !== 4'd0 || bus.bram_din !== 16'h0 || bus.rd_data !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: ack=%b we=%b val=%b last=%b avail=%b stall=%b addr=%0d din=%h rdata=%h, want all 0",
                  bus.wr_ack, bus.bram_we, bus.rd_valid, bus.rd_last, bus.rd_avail,
                  bus.wr_stall, bus.bram_addr, bus.bram_din, bus.rd_data);
      end
      apply_reset();
   endtask

   task automatic test_fill_drain();
      apply_reset();
      for (int i = 1; i <= 7; i++) write_word(16'(i));
      @(negedge clk);
      n_tests++;
      if (bus.rd_avail !== 1'b0) begin
         n_fail++;
         $display("FAIL fill_partial_avail: rd_avail=%b after 7 writes, want 0", bus.rd_avail);
      end
      @(posedge clk); #1;
      write_word(16'h0008);
      @(negedge clk);
      n_tests++;
      if (bus.rd_avail !== 1'b1 || bus.wr_stall !== 1'b0) begin
         n_fail++;
         $display("FAIL fill_done: rd_avail=%b wr_stall=%b, want 1 0", bus.rd_avail, bus.wr_stall);
      end
      @(posedge clk); #1;
      for (int i = 0; i < 8; i++) read_word();
      @(negedge clk);
      n_tests++;
      if (bus.rd_avail !== 1'b0) begin
         n_fail++;
         $display("FAIL drain_done_avail: rd_avail=%b after 8 reads, want 0", bus.rd_avail);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_stall();
      apply_reset();
      for (int i = 0; i < 16; i++) write_word(16'h0100 + 16'(i));
      @(negedge clk);
      n_tests++;
      if (bus.wr_stall !== 1'b1 || bus.rd_avail !== 1'b1) begin
         n_fail++;
         $display("FAIL both_full: wr_stall=%b rd_avail=%b, want 1 1", bus.wr_stall, bus.rd_avail);
      end
      @(posedge clk); #1;
      bus.wr_req  = 1'b1;
      bus.wr_data = 16'h0111;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_tests++;
         if (bus.wr_ack !== 1'b0 || bus.bram_we !== 1'b0) begin
            n_fail++;
            $display("FAIL stalled_write: wr_ack=%b bram_we=%b while both banks full, want 0 0",
                     bus.wr_ack, bus.bram_we);
         end
         @(posedge clk); #1;
      end
      for (int i = 0; i < 8; i++) begin
         bus.rd_req = 1'b1;
         @(negedge clk);
         n_tests++;
         if (bus.wr_ack !== 1'b0 || bus.bram_we !== 1'b0 || bus.bram_addr !== exp_ra) begin
            n_fail++;
            $display("FAIL stall_drain: ack=%b we=%b addr=%0d, want 0 0 %0d",
                     bus.wr_ack, bus.bram_we, bus.bram_addr, exp_ra);
         end
         @(posedge clk); #1;
         bus.rd_req = 1'b0;
         exp_ra = exp_ra + 4'd1;
      end
      @(negedge clk);
      n_tests++;
      if (bus.wr_ack !== 1'b1 || bus.bram_addr !== exp_wa || bus.bram_din !== 16'h0111) begin
         n_fail++;
         $display("FAIL stall_release: ack=%b addr=%0d din=%h, want 1 %0d 0111",
                  bus.wr_ack, bus.bram_addr, bus.bram_din, exp_wa);
      end
      model_push(16'h0111);
      @(posedge clk); #1;
      bus.wr_req = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [15:0] wd;
      apply_reset();
      for (int i = 0; i < 8; i++) write_word(16'h0200 + 16'(i));
      wd = 16'h0300;
      bus.wr_req  = 1'b1;
      bus.rd_req  = 1'b1;
      bus.wr_data = wd;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         n_tests++;
         if ((k % 2) == 0) begin
            if (bus.wr_ack !== 1'b0 || bus.bram_we !== 1'b0 || bus.bram_addr !== exp_ra) begin
               n_fail++;
               $display("FAIL rr_read_turn k=%0d: ack=%b we=%b addr=%0d, want 0 0 %0d",
                        k, bus.wr_ack, bus.bram_we, bus.bram_addr, exp_ra);
            end
            exp_ra = exp_ra + 4'd1;
         end else begin
            if (bus.wr_ack !== 1'b1 || bus.bram_addr !== exp_wa || bus.bram_din !== wd) begin
               n_fail++;
               $display("FAIL rr_write_turn k=%0d: ack=%b addr=%0d din=%h, want 1 %0d %h",
                        k, bus.wr_ack, bus.bram_addr, bus.bram_din, exp_wa, wd);
            end
            model_push(wd);
            wd = wd + 16'd1;
         end
         @(posedge clk); #1;
         bus.wr_data = wd;
      end
      bus.wr_req = 1'b0;
      bus.rd_req = 1'b0;
   endtask

   task automatic test_reset_mid();
      apply_reset();
      for (int i = 0; i < 5; i++) write_word(16'h0400 + 16'(i));
      rst = 1'b1;
      model_flush();
      @(negedge clk);
      n_tests++;
      if ({bus.wr_ack, bus.bram_we, bus.rd_valid, bus.rd_avail, bus.wr_stall} !== 5'b0 ||
          bus.bram_addr !== 4'd0) begin
         n_fail++;
         $display("FAIL midrst_during: ack=%b we=%b val=%b avail=%b stall=%b addr=%0d, want all 0",
                  bus.wr_ack, bus.bram_we, bus.rd_valid, bus.rd_avail, bus.wr_stall, bus.bram_addr);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({bus.rd_avail, bus.wr_stall, bus.rd_valid} !== 3'b0 || bus.bram_addr !== 4'd0) begin
         n_fail++;
         $display("FAIL midrst_after: avail=%b stall=%b val=%b addr=%0d, want 0 0 0 0",
                  bus.rd_avail, bus.wr_stall, bus.rd_valid, bus.bram_addr);
      end
      @(posedge clk); #1;
      write_word(16'h0500);
   endtask

   task automatic test_read_before_rst();
      apply_reset();
      for (int i = 0; i < 8; i++) write_word(16'h0600 + 16'(i));
      bus.rd_req = 1'b1;
      @(negedge clk);
      n_tests++;
      if (bus.bram_addr !== 4'd0 || bus.bram_we !== 1'b0) begin
         n_fail++;
         $display("FAIL prerst_issue: addr=%0d we=%b, want 0 0", bus.bram_addr, bus.bram_we);
      end
      @(posedge clk); #1;
      bus.rd_req = 1'b0;
      rst = 1'b1;
      model_flush();
      @(negedge clk);
      n_tests++;
      if (bus.rd_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL prerst_valid_in_rst: rd_valid=%b, want 0", bus.rd_valid);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      n_tests++;
      if (bus.rd_valid !== 1'b0 || bus.rd_avail !== 1'b0) begin
         n_fail++;
         $display("FAIL prerst_after: rd_valid=%b rd_avail=%b, want 0 0", bus.rd_valid, bus.rd_avail);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      bus.wr_req  = 1'b0;
      bus.rd_req  = 1'b0;
      bus.wr_data = '0;
      test_reset();
      test_fill_drain();
      test_stall();
      test_back_to_back();
      test_reset_mid();
      test_read_before_rst();
      repeat (3) @(posedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
